// File: rtl/onehot_dec_pkg.sv
// Shared encodings for the sequenced one-hot decoder: transfer modes and FSM states.
// Imported by the top so both sides of the handshake use the same code values.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_PULSE = 2'd1,
    MODE_TIMED = 2'd2,
    MODE_SCAN  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    PULSE = 3'd2,
    TIMED = 3'd3,
    SCAN  = 3'd4
  } state_e;

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational SEL_W -> 2**SEL_W one-hot decode with enable; the parametrised
// successor of the fixed 2-to-4 gate decoder. All outputs are low when disabled.
module onehot_dec_core #(
  parameter int SEL_W = 2
) (
  input  logic               i_en,
  input  logic [SEL_W-1:0]   i_sel,
  output logic [2**SEL_W-1:0] o_onehot
);

  localparam int NUM_CODES = 2**SEL_W;

  for (genvar g = 0; g < NUM_CODES; g++) begin : g_line
    assign o_onehot[g] = i_en && (i_sel == SEL_W'(g));
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with valid/ready input and LEVEL/PULSE/TIMED/SCAN output timing.
// All outputs are registered; ACTIVE_LOW inverts dout at the output register.
//
//   state | meaning
//   IDLE  | dout idle, ready for a transfer
//   HOLD  | LEVEL code held until replaced or disabled
//   PULSE | code asserted for a single cycle
//   TIMED | code asserted for max(hold_len,1) cycles
//   SCAN  | walking every code, max(hold_len,1) cycles each
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int HOLD_W     = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [1:0]          i_mode,
  input  logic [HOLD_W-1:0]   i_hold_len,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_sel_valid,
  output logic                o_sel_ready,
  output logic [2**SEL_W-1:0] o_dout,
  output logic                o_busy,
  output logic                o_done
);

  localparam int                 NUM_CODES = 2**SEL_W;
  localparam int                 LEFT_W    = SEL_W + 1;
  localparam logic [NUM_CODES-1:0] IDLE_VAL = {NUM_CODES{ACTIVE_LOW}};
  localparam logic [HOLD_W-1:0]  CNT_ONE   = HOLD_W'(1);
  localparam logic [LEFT_W-1:0]  LEFT_ONE  = LEFT_W'(1);
  localparam logic [LEFT_W-1:0]  LEFT_ALL  = LEFT_W'(NUM_CODES);

  state_e                 r_state;
  logic [NUM_CODES-1:0]   r_dout;
  logic                   r_sel_ready;
  logic                   r_busy;
  logic                   r_done;
  logic [HOLD_W-1:0]      r_cnt;
  logic [HOLD_W-1:0]      r_hold;
  logic [SEL_W-1:0]       r_idx;
  logic [LEFT_W-1:0]      r_left;

  logic                   w_accept;
  logic [HOLD_W-1:0]      w_hold_eff;
  logic [SEL_W-1:0]       w_dec_sel;
  logic [NUM_CODES-1:0]   w_onehot;
  logic [NUM_CODES-1:0]   w_dout_nxt;

  // r_sel_ready is only ever high in IDLE/HOLD, so accepts never collide with completion.
  assign w_accept   = i_sel_valid && r_sel_ready && i_en;
  assign w_hold_eff = (i_hold_len == '0) ? CNT_ONE : i_hold_len;
  assign w_dec_sel  = w_accept ? i_sel : (r_idx + SEL_W'(1));

  onehot_dec_core #(
    .SEL_W (SEL_W)
  ) u_core (
    .i_en     (i_en),
    .i_sel    (w_dec_sel),
    .o_onehot (w_onehot)
  );

  assign w_dout_nxt = w_onehot ^ IDLE_VAL;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_dout      <= IDLE_VAL;
      r_sel_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_idx       <= '0;
      r_left      <= '0;
    end else begin
      r_done <= 1'b0;
      if (!i_en) begin
        r_state     <= IDLE;
        r_dout      <= IDLE_VAL;
        r_sel_ready <= 1'b0;
        r_busy      <= 1'b0;
        r_cnt       <= '0;
        r_hold      <= '0;
        r_idx       <= '0;
        r_left      <= '0;
      end else if (w_accept) begin
        r_dout <= w_dout_nxt;
        r_busy <= 1'b1;
        r_idx  <= i_sel;
        r_hold <= w_hold_eff;
        r_cnt  <= w_hold_eff;
        r_left <= LEFT_ALL;
        case (i_mode)
          MODE_LEVEL: begin
            r_state     <= HOLD;
            r_sel_ready <= 1'b1;
          end
          MODE_PULSE: begin
            r_state     <= PULSE;
            r_sel_ready <= 1'b0;
          end
          MODE_TIMED: begin
            r_state     <= TIMED;
            r_sel_ready <= 1'b0;
          end
          default: begin
            r_state     <= SCAN;
            r_sel_ready <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          IDLE: begin
            r_sel_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_dout      <= IDLE_VAL;
          end
          HOLD: begin
            r_sel_ready <= 1'b1;
          end
          PULSE: begin
            r_state     <= IDLE;
            r_dout      <= IDLE_VAL;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_sel_ready <= 1'b1;
            r_cnt       <= '0;
          end
          TIMED: begin
            if (r_cnt == CNT_ONE) begin
              r_state     <= IDLE;
              r_dout      <= IDLE_VAL;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_sel_ready <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          SCAN: begin
            // Dwell expired: either the last code has been shown or move to the next one.
            if (r_cnt == CNT_ONE) begin
              if (r_left == LEFT_ONE) begin
                r_state     <= IDLE;
                r_dout      <= IDLE_VAL;
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_sel_ready <= 1'b1;
                r_cnt       <= '0;
                r_left      <= '0;
              end else begin
                r_idx  <= r_idx + SEL_W'(1);
                r_left <= r_left - LEFT_ONE;
                r_cnt  <= r_hold;
                r_dout <= w_dout_nxt;
              end
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_dout      <= IDLE_VAL;
            r_busy      <= 1'b0;
            r_sel_ready <= 1'b0;
            r_cnt       <= '0;
          end
        endcase
      end
    end
  end

  assign o_sel_ready = r_sel_ready;
  assign o_dout      = r_dout;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: an active-high SEL_W=2 instance and an
// ACTIVE_LOW SEL_W=3 instance, with hand-computed expected outputs.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic       en, sel_valid;
  logic [1:0] mode;
  logic [7:0] hold_len;
  logic [1:0] sel;
  logic       sel_ready, busy, done;
  logic [3:0] dout;

  logic       en_al, sel_valid_al;
  logic [1:0] mode_al;
  logic [7:0] hold_len_al;
  logic [2:0] sel_al;
  logic       sel_ready_al, busy_al, done_al;
  logic [7:0] dout_al;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.SEL_W(2), .HOLD_W(8), .ACTIVE_LOW(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_hold_len(hold_len),
    .i_sel(sel), .i_sel_valid(sel_valid), .o_sel_ready(sel_ready), .o_dout(dout),
    .o_busy(busy), .o_done(done));

  onehot_decoder_seq #(.SEL_W(3), .HOLD_W(8), .ACTIVE_LOW(1'b1)) u_dut_al (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_al), .i_mode(mode_al), .i_hold_len(hold_len_al),
    .i_sel(sel_al), .i_sel_valid(sel_valid_al), .o_sel_ready(sel_ready_al), .o_dout(dout_al),
    .o_busy(busy_al), .o_done(done_al));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [1:0] s, input logic [7:0] h);
    mode = m; sel = s; hold_len = h; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  logic [3:0] scan_exp [8];

  initial begin
    scan_exp = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    en = 1'b1; sel_valid = 1'b0; mode = 2'd0; hold_len = 8'd0; sel = 2'd0;
    en_al = 1'b1; sel_valid_al = 1'b0; mode_al = 2'd0; hold_len_al = 8'd0; sel_al = 3'd0;

    tick(); tick();
    chk("rst_dout", dout, 4'b0000);
    chk("rst_ready", sel_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_al_dout", dout_al, 8'hFF);

    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("ready_after_rel", sel_ready, 1'b1);
    chk("idle_dout", dout, 4'b0000);

    // LEVEL sel=2
    send(2'd0, 2'd2, 8'd0);
    chk("level_dout", dout, 4'b0100);
    chk("level_busy", busy, 1'b1);
    chk("level_done", done, 1'b0);
    chk("level_ready", sel_ready, 1'b1);
    tick();
    chk("level_hold", dout, 4'b0100);

    // PULSE sel=3 straight out of HOLD, no idle gap
    send(2'd1, 2'd3, 8'd0);
    chk("pulse_dout", dout, 4'b1000);
    chk("pulse_ready", sel_ready, 1'b0);
    chk("pulse_done0", done, 1'b0);
    tick();
    chk("pulse_end_dout", dout, 4'b0000);
    chk("pulse_end_done", done, 1'b1);
    chk("pulse_end_busy", busy, 1'b0);
    tick();
    chk("pulse_done_clr", done, 1'b0);
    chk("pulse_ready_back", sel_ready, 1'b1);

    // TIMED sel=1 hold 5
    send(2'd2, 2'd1, 8'd5);
    for (int i = 0; i < 5; i++) begin
      chk("timed5_dout", dout, 4'b0010);
      chk("timed5_ready", sel_ready, 1'b0);
      chk("timed5_done", done, 1'b0);
      tick();
    end
    chk("timed5_end_dout", dout, 4'b0000);
    chk("timed5_end_done", done, 1'b1);

    // TIMED hold 0 behaves as 1
    tick();
    send(2'd2, 2'd1, 8'd0);
    chk("timed0_dout", dout, 4'b0010);
    tick();
    chk("timed0_end_dout", dout, 4'b0000);
    chk("timed0_end_done", done, 1'b1);

    // SCAN from 2 with wrap, dwell 2
    tick();
    send(2'd3, 2'd2, 8'd2);
    for (int i = 0; i < 8; i++) begin
      chk("scan_dout", dout, scan_exp[i]);
      chk("scan_done", done, 1'b0);
      chk("scan_busy", busy, 1'b1);
      tick();
    end
    chk("scan_end_dout", dout, 4'b0000);
    chk("scan_end_done", done, 1'b1);
    chk("scan_end_busy", busy, 1'b0);

    // Abort SCAN with en=0
    tick();
    send(2'd3, 2'd0, 8'd3);
    chk("abort_scan_dout", dout, 4'b0001);
    tick();
    en = 1'b0;
    tick();
    chk("abort_en_dout", dout, 4'b0000);
    chk("abort_en_busy", busy, 1'b0);
    chk("abort_en_done", done, 1'b0);
    chk("abort_en_ready", sel_ready, 1'b0);
    en = 1'b1;
    tick();
    chk("abort_en_ready_back", sel_ready, 1'b1);
    chk("abort_en_nodone", done, 1'b0);

    // HOLD: accept and en=0 on same edge, en wins
    send(2'd0, 2'd1, 8'd0);
    chk("hold2_dout", dout, 4'b0010);
    sel_valid = 1'b1; sel = 2'd3; en = 1'b0;
    tick();
    sel_valid = 1'b0; en = 1'b1;
    chk("en_wins_dout", dout, 4'b0000);
    chk("en_wins_busy", busy, 1'b0);
    tick();

    // Async reset mid-SCAN, asserted between edges
    send(2'd3, 2'd1, 8'd4);
    chk("rst_scan_dout", dout, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 4'b0000);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("async_rst_ready", sel_ready, 1'b1);
    chk("async_rst_nodone", done, 1'b0);

    // ACTIVE_LOW SEL_W=3 instance
    chk("al_idle", dout_al, 8'hFF);
    mode_al = 2'd0; sel_al = 3'd5; sel_valid_al = 1'b1;
    tick();
    sel_valid_al = 1'b0;
    chk("al_level_dout", dout_al, 8'b1101_1111);
    chk("al_level_busy", busy_al, 1'b1);
    en_al = 1'b0;
    tick();
    chk("al_disable_dout", dout_al, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake and three output-timing modes.
- Adds a self-running scan mode that walks the one-hot output across every code, for lamp/bus-select sequencing and board bring-up.
- Sits between control logic issuing select codes and downstream enable lines: chip selects, mux selects, LED drivers.

Parameters:
- SEL_W, 2, width of select code; output width is 2**SEL_W (legal 1..6).
- HOLD_W, 8, width of the hold-length counter used in TIMED mode and scan dwell.
- ACTIVE_LOW, 0, 1 inverts every bit of dout at the output register; idle then reads all ones.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; 0 forces dout idle and FSM to IDLE on next edge.
- mode  in  2  0=LEVEL, 1=PULSE, 2=TIMED, 3=SCAN; sampled only on an accepted transfer.
- hold_len  in  HOLD_W  cycles an output stays asserted in TIMED/SCAN; sampled on accept; value 0 is treated as 1.
- sel  in  SEL_W  code to decode.
- sel_valid  in  1  sel/mode/hold_len valid.
- sel_ready  out  1  block can accept a transfer.
- dout  out  2**SEL_W  registered one-hot (or one-cold) output.
- busy  out  1  1 while dout is non-idle or a scan is in progress.
- done  out  1  one-cycle strobe when PULSE, TIMED or SCAN completes.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, dout=idle (all 0, or all 1 if ACTIVE_LOW), sel_ready=0, busy=0, done=0, counters=0. sel_ready rises on the first edge after reset release.
- A transfer is accepted on a rising edge with sel_valid & sel_ready & en. dout reflects the accepted code on the following edge (1-cycle latency): bit sel set, all others clear.
- IDLE: sel_ready=1. Accept -> LEVEL: HOLD; PULSE: PULSE; TIMED: TIMED; SCAN: SCAN with scan index = sel (start code).
- HOLD (LEVEL mode): dout holds the code indefinitely. sel_ready=1; a new accept replaces dout on the next edge with no idle gap, and the new mode takes effect. No done strobe in LEVEL.
- PULSE: dout asserted exactly 1 cycle, then idle. done=1 in the cycle dout returns to idle. Return to IDLE. sel_ready=0 while in PULSE.
- TIMED: dout asserted for max(hold_len,1) cycles, then idle with done=1. Return to IDLE. sel_ready=0 throughout.
- SCAN: starting at code sel, assert each code for max(hold_len,1) cycles. Increment the index modulo 2**SEL_W. Stop after all 2**SEL_W codes (wrap-around included): dout idle, done=1, IDLE. sel_ready=0 throughout.
- busy=1 exactly when state is not IDLE; in HOLD, busy=1 while dout is non-idle.
- en=0 at any edge: abort to IDLE, dout idle, no done strobe, counters cleared. sel_ready=0 while en=0.
- Reset mid-operation: immediate idle as above; no done.
- Simultaneous accept and completion cannot occur, because sel_ready=0 in timed states. In HOLD, an accept and en=0 on the same edge: en wins.
- sel_valid may drop without being accepted; there is no stickiness requirement on sources.
- The hold counter is HOLD_W bits and counts down from the loaded value; it must not wrap.

Decomposition:
- Shared package onehot_dec_pkg: mode encodings (MODE_LEVEL/PULSE/TIMED/SCAN), FSM state enum (IDLE, HOLD, PULSE, TIMED, SCAN).
- One sub-module, onehot_dec_core: purely combinational SEL_W -> 2**SEL_W decode with enable, a generalisation of the existing 2-to-4 gate decoder. The top instantiates it ahead of the output register and applies ACTIVE_LOW after it.

Test Plan:
- Reset/handshake: SEL_W=2, rst_n low then high -> dout=0000, sel_ready=1 one cycle after release. Send sel=2 LEVEL -> dout=0100 next cycle, busy=1, no done.
- PULSE: sel=3 mode=1 -> dout=1000 for exactly 1 cycle, then 0000 with done=1 that cycle. sel_ready=0 during the pulse.
- TIMED: sel=1 mode=2 hold_len=5 -> dout=0010 for 5 cycles, then done pulse. Repeat with hold_len=0 -> 1 cycle.
- SCAN with wrap: sel=2 mode=3 hold_len=2 -> dout sequence 0100,0100,1000,1000,0001,0001,0010,0010, then 0000 with done=1.
- Abort: mid-SCAN drop en for 1 cycle -> dout=0000 next edge, state IDLE, no done. Repeat with rst_n pulsed low asynchronously between edges -> dout clears immediately.
- ACTIVE_LOW=1, SEL_W=3: LEVEL sel=5 -> dout=8'b11011111. After reset -> 8'hFF.
